// File: rtl/packetizer_serial.sv
// Serial NoC packetizer: latches one payload+destination per handshake and
// streams it out as head/body/tail flits, one per cycle, with back-to-back reload.
module packetizer_serial #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 36,
  parameter int FLIT_WIDTH       = 16,
  parameter int ASSIGNED_VC      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_IN-1:0]      data_in,
  input  logic                     valid_in,
  input  logic [ADDRESS_WIDTH-1:0] dst_in,
  output logic                     ready_out,
  output logic [FLIT_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_in
);

  // state | meaning
  // IDLE  | no packet held; ready for a new one, outputs zero
  // SEND  | presenting flit flit_cnt of the latched packet
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam int HEAD_PAY  = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int BODY_PAY  = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH;
  localparam int NUM_FLITS = (WIDTH_IN <= HEAD_PAY) ? 1
                           : 1 + (WIDTH_IN - HEAD_PAY + BODY_PAY - 1) / BODY_PAY;
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  // Payload is MSB-aligned in a buffer wide enough that every flit slice is in range.
  localparam int PAD_W     = HEAD_PAY + NUM_FLITS * BODY_PAY;
  localparam int IDX_W     = $clog2(PAD_W);

  localparam logic [CNT_W-1:0]            LAST_CNT = CNT_W'(NUM_FLITS - 1);
  localparam logic [VC_ADDRESS_WIDTH-1:0] VC_VAL   = VC_ADDRESS_WIDTH'(ASSIGNED_VC);

  if (HEAD_PAY < 1) begin : g_bad_cfg
    $error("packetizer_serial: FLIT_WIDTH leaves no room for head payload");
  end

  logic [0:0]               state;
  logic [CNT_W-1:0]         flit_cnt;
  logic [WIDTH_IN-1:0]      data_reg;
  logic [ADDRESS_WIDTH-1:0] dst_reg;

  logic                     is_head;
  logic                     is_tail;
  logic                     tail_accept;
  logic [PAD_W-1:0]         padded;
  logic [IDX_W-1:0]         body_lsb;
  logic [FLIT_WIDTH-1:0]    flit;

  assign is_head     = (flit_cnt == '0);
  assign is_tail     = (flit_cnt == LAST_CNT);
  assign tail_accept = (state == SEND) && ready_in && is_tail;

  assign ready_out = (state == IDLE) || tail_accept;
  assign valid_out = (state == SEND);
  assign data_out  = flit;

  always_comb begin
    padded = '0;
    padded[PAD_W-1 -: WIDTH_IN] = data_reg;
    body_lsb = '0;
    if (!is_head) begin
      body_lsb = IDX_W'(PAD_W - HEAD_PAY - int'(flit_cnt) * BODY_PAY);
    end
  end

  always_comb begin
    flit = '0;
    if (state == SEND) begin
      flit[FLIT_WIDTH-1] = 1'b1;
      flit[FLIT_WIDTH-2] = is_head;
      flit[FLIT_WIDTH-3] = is_tail;
      flit[FLIT_WIDTH-4 -: VC_ADDRESS_WIDTH] = VC_VAL;
      if (is_head) begin
        flit[FLIT_WIDTH-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH] = dst_reg;
        flit[HEAD_PAY-1:0] = padded[PAD_W-1 -: HEAD_PAY];
      end else begin
        flit[BODY_PAY-1:0] = padded[body_lsb +: BODY_PAY];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flit_cnt <= '0;
      data_reg <= '0;
      dst_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            data_reg <= data_in;
            dst_reg  <= dst_in;
            flit_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (ready_in) begin
            if (!is_tail) begin
              flit_cnt <= flit_cnt + 1'b1;
            end else if (valid_in) begin
              // Reload on tail acceptance so packets run back-to-back.
              data_reg <= data_in;
              dst_reg  <= dst_in;
              flit_cnt <= '0;
            end else begin
              state    <= IDLE;
              flit_cnt <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          flit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packetizer_serial.sv
// Bench for packetizer_serial: directed flit sequences plus a randomized run
// checked by a depacketizer model that reassembles payloads from the flit stream.
module tb_packetizer_serial;

  logic        clk;
  logic        rst;
  logic [35:0] data_in;
  logic        valid_in;
  logic [3:0]  dst_in;
  logic        ready_out;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_in;

  logic [7:0]  data_in8;
  logic        valid_in8;
  logic [3:0]  dst_in8;
  logic        ready_out8;
  logic [15:0] data_out8;
  logic        valid_out8;
  logic        ready_in8;

  int checks = 0;
  int errors = 0;

  packetizer_serial dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .dst_in(dst_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  packetizer_serial #(.WIDTH_IN(8)) dut8 (
    .clk(clk), .rst(rst), .data_in(data_in8), .valid_in(valid_in8), .dst_in(dst_in8),
    .ready_out(ready_out8), .data_out(data_out8), .valid_out(valid_out8), .ready_in(ready_in8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic [15:0] flit, input logic rdy);
    #1;
    check({tag, "_valid"}, 64'(valid_out), 64'd1);
    check({tag, "_data"},  64'(data_out),  64'(flit));
    check({tag, "_ready"}, 64'(ready_out), 64'(rdy));
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_data"},  64'(data_out),  64'd0);
    check({tag, "_ready"}, 64'(ready_out), 64'd1);
  endtask

  // Depacketizer reference: a queue of accepted {dst,data} and bit accumulation
  logic [39:0] sb_q[$];
  logic [63:0] acc;
  logic [3:0]  rx_dst;
  logic [39:0] exp_pkt;
  logic [15:0] f;
  logic [15:0] prev_data;
  logic        prev_stall;
  int          nfl;
  int          in_pkt;
  int          heads, tails, accepted;

  task automatic model_flit(input logic [15:0] fl);
    check("rnd_vbit", 64'(fl[15]), 64'd1);
    check("rnd_vc",   64'(fl[12]), 64'd0);
    if (fl[14]) begin
      check("rnd_head_unexpected", 64'(in_pkt), 64'd0);
      in_pkt = 1;
      rx_dst = fl[11:8];
      acc    = 64'(fl[7:0]);
      nfl    = 1;
      heads++;
    end else begin
      check("rnd_body_no_head", 64'(in_pkt), 64'd1);
      acc = (acc << 12) | 64'(fl[11:0]);
      nfl++;
    end
    if (fl[13]) begin
      tails++;
      // 8 + 3*12 = 44 bits received, the low 8 of which are padding
      check("rnd_nflits", 64'(nfl), 64'd4);
      check("rnd_pad", 64'(acc[7:0]), 64'd0);
      if (sb_q.size() == 0) begin
        check("rnd_extra_pkt", 64'd1, 64'd0);
      end else begin
        exp_pkt = sb_q.pop_front();
        check("rnd_dst",  64'(rx_dst), 64'(exp_pkt[39:36]));
        check("rnd_data", 64'(acc[43:8]), 64'(exp_pkt[35:0]));
      end
      in_pkt = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0; valid_in = 1'b0; dst_in = '0; ready_in = 1'b1;
    data_in8 = '0; valid_in8 = 1'b0; dst_in8 = '0; ready_in8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_idle("reset");
    #1;
    check("reset8_valid", 64'(valid_out8), 64'd0);
    check("reset8_ready", 64'(ready_out8), 64'd1);

    // 1: single packet, no stalls
    @(negedge clk);
    data_in = 36'h123456789; dst_in = 4'hA; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk); valid_in = 1'b0; data_in = 36'h0;
    expect_flit("t1_f0", 16'hCA12, 1'b0);
    @(negedge clk); expect_flit("t1_f1", 16'h8345, 1'b0);
    @(negedge clk); expect_flit("t1_f2", 16'h8678, 1'b0);
    @(negedge clk); expect_flit("t1_f3", 16'hA900, 1'b1);
    @(negedge clk); expect_idle("t1_end");

    // 2: stall on the second flit for two cycles
    data_in = 36'h123456789; dst_in = 4'hA; valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    expect_flit("t2_f0", 16'hCA12, 1'b0);
    @(negedge clk); ready_in = 1'b0; expect_flit("t2_s0", 16'h8345, 1'b0);
    @(negedge clk); expect_flit("t2_s1", 16'h8345, 1'b0);
    @(negedge clk); ready_in = 1'b1; expect_flit("t2_f1", 16'h8345, 1'b0);
    @(negedge clk); expect_flit("t2_f2", 16'h8678, 1'b0);
    @(negedge clk); ready_in = 1'b0; expect_flit("t2_tstall", 16'hA900, 1'b0);
    @(negedge clk); ready_in = 1'b1; expect_flit("t2_f3", 16'hA900, 1'b1);
    @(negedge clk); expect_idle("t2_end");

    // 3: back-to-back; new data presented early must be ignored until tail
    data_in = 36'h123456789; dst_in = 4'hA; valid_in = 1'b1;
    @(negedge clk); data_in = 36'hFEDCBA987; dst_in = 4'h3;
    expect_flit("t3_a0", 16'hCA12, 1'b0);
    @(negedge clk); expect_flit("t3_a1", 16'h8345, 1'b0);
    @(negedge clk); expect_flit("t3_a2", 16'h8678, 1'b0);
    @(negedge clk); expect_flit("t3_a3", 16'hA900, 1'b1);
    @(negedge clk); valid_in = 1'b0;
    expect_flit("t3_b0", 16'hC3FE, 1'b0);
    @(negedge clk); expect_flit("t3_b1", 16'h8DCB, 1'b0);
    @(negedge clk); expect_flit("t3_b2", 16'h8A98, 1'b0);
    @(negedge clk); expect_flit("t3_b3", 16'hA700, 1'b1);
    @(negedge clk); expect_idle("t3_end");

    // 5: reset while the second flit is presented
    data_in = 36'h123456789; dst_in = 4'hA; valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    expect_flit("t5_f0", 16'hCA12, 1'b0);
    @(negedge clk); expect_flit("t5_f1", 16'h8345, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    expect_idle("t5_rst");
    data_in = 36'hABCDEF012; dst_in = 4'h5; valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    expect_flit("t5_n0", 16'hC5AB, 1'b0);
    @(negedge clk); expect_flit("t5_n1", 16'h8CDE, 1'b0);
    @(negedge clk); expect_flit("t5_n2", 16'h8F01, 1'b0);
    @(negedge clk); expect_flit("t5_n3", 16'hA200, 1'b1);
    @(negedge clk); expect_idle("t5_end");

    // 4: single-flit packets on the 8-bit instance
    data_in8 = 8'h5C; dst_in8 = 4'h7; valid_in8 = 1'b1;
    @(negedge clk); valid_in8 = 1'b0;
    #1;
    check("t4_valid", 64'(valid_out8), 64'd1);
    check("t4_data",  64'(data_out8),  64'hE75C);
    check("t4_ready", 64'(ready_out8), 64'd1);
    @(negedge clk); #1;
    check("t4_idle_valid", 64'(valid_out8), 64'd0);
    check("t4_idle_ready", 64'(ready_out8), 64'd1);

    // 6: random traffic and stalls against the depacketizer model
    in_pkt = 0; heads = 0; tails = 0; accepted = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 2200; cyc++) begin
      @(negedge clk);
      if (cyc < 2000) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = {4'($urandom), 32'($urandom)};
        dst_in   = 4'($urandom);
        ready_in = ($urandom_range(0, 3) != 0);
      end else begin
        valid_in = 1'b0;
        ready_in = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check("rnd_stall_valid", 64'(valid_out), 64'd1);
        check("rnd_stall_data", 64'(data_out), 64'(prev_data));
      end
      if (valid_in && ready_out) begin
        sb_q.push_back({dst_in, data_in});
        accepted++;
      end
      if (valid_out && ready_in) begin
        f = data_out;
        model_flit(f);
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      if (cyc >= 2000 && !valid_out && sb_q.size() == 0) break;
    end
    check("rnd_drained", 64'(sb_q.size()), 64'd0);
    check("rnd_no_open_pkt", 64'(in_pkt), 64'd0);
    check("rnd_heads", 64'(heads), 64'(accepted));
    check("rnd_tails", 64'(tails), 64'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
